// File: rtl/xadc_drp_scheduler.sv
// -----------------------------------------------------------------------------
// xadc_drp_scheduler
//
// Shares one XADC DRP port between two clients:
//   * a scheduled reader that fetches one result register per end-of-conversion
//     pulse. It walks four slot addresses round-robin and publishes each result
//     on its own 16-bit field of slot_data.
//   * a user port that performs single DRP reads or writes with a req/ack
//     handshake.
// Scheduled work always wins arbitration. A missing drdy is bounded by a wait
// counter, and both clients see a timeout indication.
//
// Ports
//   CLK100MHZ, CPU_RESETN          clock, asynchronous active-low reset
//   eoc_in                         XADC end-of-conversion pulse
//   drdy_in, do_in                 DRP read handshake / read data
//   daddr_out, den_out, dwe_out,   DRP address, enable (1-cycle strobe),
//   di_out                         write enable, write data
//   user_req, user_we, user_addr,  user request (held until user_ack),
//   user_wdata                     direction, address, write data
//   user_ack, user_rdata, user_err one-cycle completion, read data, timeout flag
//   slot_data                      slot n result at [16n+15:16n]
//   slot_valid                     one-cycle pulse per slot update
//   overrun                        sticky: eoc arrived while one was pending
//   timeout_err                    sticky: some DRP access never saw drdy
// -----------------------------------------------------------------------------
module xadc_drp_scheduler #(
  parameter logic [6:0]  SLOT0_ADDR = 7'h13,  // VAUX3 audio result
  parameter logic [6:0]  SLOT1_ADDR = 7'h00,  // temperature
  parameter logic [6:0]  SLOT2_ADDR = 7'h01,  // VCCINT
  parameter logic [6:0]  SLOT3_ADDR = 7'h02,  // VCCAUX
  parameter int unsigned TIMEOUT    = 63      // max WAIT cycles without drdy
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,

  // XADC DRP side
  input  logic        eoc_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,

  // user side
  input  logic        user_req,
  input  logic        user_we,
  input  logic [6:0]  user_addr,
  input  logic [15:0] user_wdata,
  output logic        user_ack,
  output logic [15:0] user_rdata,
  output logic        user_err,

  // scheduled results and status
  output logic [63:0] slot_data,
  output logic [3:0]  slot_valid,
  output logic        overrun,
  output logic        timeout_err
);

  // The wait counter only has to reach TIMEOUT-1: the cycle that sees that
  // value without drdy is the last WAIT cycle.
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] U_ISSUE = 3'd3;
  localparam logic [2:0] U_WAIT  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [1:0]       slot_idx;
  logic [6:0]       slot_addr;
  logic             pending;
  logic             req_consumed;
  logic [CNT_W-1:0] wait_cnt;

  logic in_wait;
  logic wait_expired;
  logic wait_end;
  logic start_sched;
  logic start_user;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    case (slot_idx)
      2'd0:    slot_addr = SLOT0_ADDR;
      2'd1:    slot_addr = SLOT1_ADDR;
      2'd2:    slot_addr = SLOT2_ADDR;
      default: slot_addr = SLOT3_ADDR;
    endcase
  end

  assign in_wait      = (state == S_WAIT) || (state == U_WAIT);
  assign wait_expired = in_wait && !drdy_in && (wait_cnt == CNT_LAST);
  assign wait_end     = in_wait && (drdy_in || wait_expired);

  assign start_sched  = (state == IDLE) && pending;
  // An eoc arriving in the same cycle as a fresh user request becomes pending
  // only on the next edge. Deferring the user here still lets the scheduled
  // read go first, and the user is served right after it.
  assign start_user   = (state == IDLE) && !pending && !eoc_in &&
                        user_req && !req_consumed;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned, so
    // no latch is inferred for state_nxt.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_sched)     state_nxt = S_ISSUE;
        else if (start_user) state_nxt = U_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_end) state_nxt = IDLE;
      U_ISSUE: state_nxt = U_WAIT;
      U_WAIT:  if (wait_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, slot index and wait counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every block
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= IDLE;
      slot_idx <= 2'd0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Counts cycles spent in WAIT. It is zero on entry because the ISSUE
      // cycle before it is not a WAIT cycle.
      if (in_wait && !wait_end) wait_cnt <= wait_cnt + CNT_W'(1);
      else                      wait_cnt <= '0;
      // A scheduled slot is consumed whether it completed or timed out.
      if (state == S_WAIT && wait_end) slot_idx <= slot_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // End-of-conversion tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (eoc_in) begin
        pending <= 1'b1;
        // An eoc that lands while pending is being consumed simply re-arms it.
        if (pending && !start_sched) overrun <= 1'b1;
      end else if (start_sched) begin
        pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DRP request outputs
  // ---------------------------------------------------------------------------
  // These outputs are loaded on the IDLE->ISSUE edge, so den_out is high during
  // the ISSUE cycle only. Address, direction and data then hold until the next
  // issue.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      den_out   <= 1'b0;
      dwe_out   <= 1'b0;
      daddr_out <= '0;
      di_out    <= '0;
    end else begin
      den_out <= 1'b0;
      if (start_sched) begin
        den_out   <= 1'b1;
        dwe_out   <= 1'b0;
        daddr_out <= slot_addr;
      end else if (start_user) begin
        den_out   <= 1'b1;
        dwe_out   <= user_we;
        daddr_out <= user_addr;
        di_out    <= user_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduled results
  // ---------------------------------------------------------------------------
  // NOTE: slot_data is a small register bank, not a RAM. It can therefore take
  // the asynchronous reset like any other flop.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      slot_data   <= '0;
      slot_valid  <= '0;
      timeout_err <= 1'b0;
    end else begin
      slot_valid <= '0;
      if (state == S_WAIT && drdy_in) begin
        slot_data[{slot_idx, 4'b0000} +: 16] <= do_in;
        slot_valid <= 4'b0001 << slot_idx;
      end
      if (wait_expired) timeout_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // User completion
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      user_ack     <= 1'b0;
      user_err     <= 1'b0;
      user_rdata   <= '0;
      req_consumed <= 1'b0;
    end else begin
      user_ack <= 1'b0;
      user_err <= 1'b0;
      if (state == U_WAIT && drdy_in) begin
        user_ack <= 1'b1;
        // dwe_out still holds the captured direction; writes return no data.
        if (!dwe_out) user_rdata <= do_in;
      end else if (state == U_WAIT && wait_expired) begin
        user_ack <= 1'b1;
        user_err <= 1'b1;
      end
      // The requester still holds user_req during the ack cycle. The request
      // counts as used until user_req is seen low.
      if (state == U_WAIT && wait_end) req_consumed <= 1'b1;
      else if (!user_req)              req_consumed <= 1'b0;
    end
  end

endmodule

// File: doc/xadc_drp_scheduler.md
XADC_DRP_SCHEDULER -- requirements
Module: xadc_drp_scheduler

Interface
REQ-001 SHALL have parameters: SLOT0_ADDR, default 7'h13, VAUX3 audio result register; SLOT1_ADDR, default 7'h00, temperature; SLOT2_ADDR, default 7'h01, VCCINT; SLOT3_ADDR, default 7'h02, VCCAUX; TIMEOUT, default 63, max cycles waiting for drdy.
REQ-002 SHALL have one clock and an asynchronous active-low reset: CLK100MHZ  in  1  clock; CPU_RESETN  in  1  reset.
REQ-003 SHALL have XADC-side ports: eoc_in  in  1  end-of-conversion pulse; drdy_in  in  1  DRP data ready; do_in  in  16  DRP read data; daddr_out  out  7  DRP address; den_out  out  1  DRP enable; dwe_out  out  1  DRP write enable; di_out  out  16  DRP write data.
REQ-004 SHALL have user-side ports: user_req  in  1  request, held until ack; user_we  in  1  1=write; user_addr  in  7; user_wdata  in  16; user_ack  out  1  one-cycle completion; user_rdata  out  16; user_err  out  1  valid with ack, timeout.
REQ-005 SHALL have result ports: slot_data  out  64  slot n at [16n+15:16n]; slot_valid  out  4  one-cycle pulse on slot update; overrun  out  1  sticky; timeout_err  out  1  sticky.

Function
REQ-006 SHALL implement states IDLE, S_ISSUE, S_WAIT, U_ISSUE, U_WAIT.
REQ-007 SHALL set a pending flag on eoc_in in any state; a second eoc_in while pending is set SHALL set overrun and leave pending set.
REQ-008 In IDLE, pending SHALL take priority: go to S_ISSUE and clear pending; else user_req=1 goes to U_ISSUE; else stay.
REQ-009 eoc_in in the same cycle pending is cleared SHALL re-set pending without overrun.
REQ-010 S_ISSUE SHALL drive den_out=1, dwe_out=0, daddr_out=address of current slot index for exactly one cycle, then go to S_WAIT.
REQ-011 U_ISSUE SHALL drive den_out=1, dwe_out=user_we, daddr_out=user_addr, di_out=user_wdata for one cycle, then go to U_WAIT; user inputs are captured at entry to U_ISSUE.
REQ-012 daddr_out, dwe_out, di_out SHALL hold their issued values through the WAIT state; den_out SHALL be 0 outside ISSUE states.
REQ-013 In S_WAIT, drdy_in=1 SHALL write do_in to the current slot's slot_data field, pulse that slot_valid bit next cycle, advance slot index 0-1-2-3-0, and return to IDLE.
REQ-014 In U_WAIT, drdy_in=1 SHALL register user_rdata=do_in (unchanged for writes), pulse user_ack with user_err=0, and return to IDLE.
REQ-015 A wait counter SHALL clear on entering a WAIT state and increment each WAIT cycle; reaching TIMEOUT without drdy_in SHALL set timeout_err and return to IDLE.
REQ-016 Scheduled timeout SHALL leave slot_data unchanged, pulse no slot_valid, and still advance slot index; user timeout SHALL pulse user_ack with user_err=1.
REQ-017 drdy_in outside WAIT states SHALL be ignored.
REQ-018 Latency: eoc_in at cycle 0 with FSM idle -> den_out at cycle 2; drdy at cycle k -> slot_valid/slot_data at cycle k+1.
REQ-019 user_ack SHALL not repeat for a held user_req; a new transaction starts only after user_req is seen low-then-high or re-asserted after ack (ack cycle consumes the request; requester deasserts on ack).

Reset
REQ-020 CPU_RESETN=0 SHALL asynchronously force IDLE, slot index 0, pending 0, wait counter 0, all outputs 0 (slot_data, slot_valid, user_ack, user_rdata, user_err, den_out, dwe_out, daddr_out, di_out, overrun, timeout_err).
REQ-021 Reset mid-transaction SHALL abandon it with no ack or slot update; first eoc_in after release reads SLOT0_ADDR.

Verification
REQ-022 Four eoc_in pulses, model drdy 3 cycles after den, do_in=16'h1230,16'h9A40,16'h5550,16'h6660 -> daddr 13,00,01,02; slot_data=16'h6660_5550_9A40_1230; slot_valid 1,2,4,8.
REQ-023 user read addr 7'h01 with eoc_in same cycle -> scheduled read issued first, user den follows after its drdy; user_ack with user_rdata=do_in, user_err=0.
REQ-024 eoc_in twice during S_WAIT -> overrun=1, exactly one extra scheduled read.
REQ-025 drdy never returned on slot 1 -> timeout_err=1 after 63 wait cycles, slot1 unchanged, next eoc reads SLOT2_ADDR.
REQ-026 user write addr 7'h40 data 16'hA5A5 -> den=1,dwe=1,di=16'hA5A5 one cycle; ack on drdy; user timeout -> user_err=1.
REQ-027 CPU_RESETN low during S_WAIT -> all outputs 0 immediately, late drdy ignored.
